// File: rtl/axil_interconnect_1x2.sv
// axil_interconnect_1x2
// Single-clock AXI4-Lite interconnect, one slave port (s00) to two master
// ports (m00, m01). Each transaction is routed by address decode. An address
// that hits no window, or hits a window whose direction is disconnected, is
// answered locally with DECERR (2'b11).
//
// Ports:
//   clk, rst               - sole clock (rising edge), async active-high reset
//   s00_axil_aw*/w*/b*     - slave write channels (from the upstream master)
//   s00_axil_ar*/r*        - slave read channels
//   mNN_axil_aw*/w*/b*     - master write channels toward target NN
//   mNN_axil_ar*/r*        - master read channels toward target NN
//
// Reads and writes are served by independent FSMs, each with one transaction
// in flight. Every output is driven straight from a register.
module axil_interconnect_1x2 #(
    parameter int unsigned            DATA_WIDTH        = 32,
    parameter int unsigned            ADDR_WIDTH        = 32,
    parameter int unsigned            STRB_WIDTH        = DATA_WIDTH/8,
    parameter logic [ADDR_WIDTH-1:0]  M00_BASE_ADDR     = '0,
    parameter int unsigned            M00_ADDR_WIDTH    = 24,
    parameter bit                     M00_CONNECT_READ  = 1'b1,
    parameter bit                     M00_CONNECT_WRITE = 1'b1,
    parameter logic [ADDR_WIDTH-1:0]  M01_BASE_ADDR     = ADDR_WIDTH'(32'h0100_0000),
    parameter int unsigned            M01_ADDR_WIDTH    = 24,
    parameter bit                     M01_CONNECT_READ  = 1'b1,
    parameter bit                     M01_CONNECT_WRITE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    // s00 slave port
    input  logic [ADDR_WIDTH-1:0] s00_axil_awaddr,
    input  logic [2:0]            s00_axil_awprot,
    input  logic                  s00_axil_awvalid,
    output logic                  s00_axil_awready,
    input  logic [DATA_WIDTH-1:0] s00_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s00_axil_wstrb,
    input  logic                  s00_axil_wvalid,
    output logic                  s00_axil_wready,
    output logic [1:0]            s00_axil_bresp,
    output logic                  s00_axil_bvalid,
    input  logic                  s00_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s00_axil_araddr,
    input  logic [2:0]            s00_axil_arprot,
    input  logic                  s00_axil_arvalid,
    output logic                  s00_axil_arready,
    output logic [DATA_WIDTH-1:0] s00_axil_rdata,
    output logic [1:0]            s00_axil_rresp,
    output logic                  s00_axil_rvalid,
    input  logic                  s00_axil_rready,
    // m00 master port
    output logic [ADDR_WIDTH-1:0] m00_axil_awaddr,
    output logic [2:0]            m00_axil_awprot,
    output logic                  m00_axil_awvalid,
    input  logic                  m00_axil_awready,
    output logic [DATA_WIDTH-1:0] m00_axil_wdata,
    output logic [STRB_WIDTH-1:0] m00_axil_wstrb,
    output logic                  m00_axil_wvalid,
    input  logic                  m00_axil_wready,
    input  logic [1:0]            m00_axil_bresp,
    input  logic                  m00_axil_bvalid,
    output logic                  m00_axil_bready,
    output logic [ADDR_WIDTH-1:0] m00_axil_araddr,
    output logic [2:0]            m00_axil_arprot,
    output logic                  m00_axil_arvalid,
    input  logic                  m00_axil_arready,
    input  logic [DATA_WIDTH-1:0] m00_axil_rdata,
    input  logic [1:0]            m00_axil_rresp,
    input  logic                  m00_axil_rvalid,
    output logic                  m00_axil_rready,
    // m01 master port
    output logic [ADDR_WIDTH-1:0] m01_axil_awaddr,
    output logic [2:0]            m01_axil_awprot,
    output logic                  m01_axil_awvalid,
    input  logic                  m01_axil_awready,
    output logic [DATA_WIDTH-1:0] m01_axil_wdata,
    output logic [STRB_WIDTH-1:0] m01_axil_wstrb,
    output logic                  m01_axil_wvalid,
    input  logic                  m01_axil_wready,
    input  logic [1:0]            m01_axil_bresp,
    input  logic                  m01_axil_bvalid,
    output logic                  m01_axil_bready,
    output logic [ADDR_WIDTH-1:0] m01_axil_araddr,
    output logic [2:0]            m01_axil_arprot,
    output logic                  m01_axil_arvalid,
    input  logic                  m01_axil_arready,
    input  logic [DATA_WIDTH-1:0] m01_axil_rdata,
    input  logic [1:0]            m01_axil_rresp,
    input  logic                  m01_axil_rvalid,
    output logic                  m01_axil_rready
);

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_t;

    // Result is {hit, select}; select 0 = m00, 1 = m01. m00 wins on overlap.
    function automatic logic [1:0] f_decode(input logic [ADDR_WIDTH-1:0] addr, input logic is_write);
        logic m0, m1;
        m0 = ((addr >> M00_ADDR_WIDTH) == (M00_BASE_ADDR >> M00_ADDR_WIDTH)) &&
             (is_write ? M00_CONNECT_WRITE : M00_CONNECT_READ);
        m1 = ((addr >> M01_ADDR_WIDTH) == (M01_BASE_ADDR >> M01_ADDR_WIDTH)) &&
             (is_write ? M01_CONNECT_WRITE : M01_CONNECT_READ);
        return {m0 | m1, ~m0 & m1};
    endfunction

    // ---------------- write path ----------------
    w_state_t              r_wstate;
    logic                  r_aw_held, r_w_held, r_wsel;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [2:0]            r_awprot;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_s_awready, r_s_wready, r_s_bvalid;
    logic [1:0]            r_s_bresp;
    logic [1:0]            r_m_awvalid, r_m_wvalid, r_m_bready;

    logic                  w_aw_hs, w_w_hs, w_aw_have, w_w_have;
    logic [ADDR_WIDTH-1:0] w_aw_addr;
    logic [1:0]            w_wdec, w_m_awready, w_m_wready, w_m_bvalid, w_m_bresp;

    assign w_aw_hs     = s00_axil_awvalid & r_s_awready;
    assign w_w_hs      = s00_axil_wvalid & r_s_wready;
    assign w_aw_have   = r_aw_held | w_aw_hs;
    assign w_w_have    = r_w_held | w_w_hs;
    // Decode from the address being captured this edge if AW was not held yet.
    assign w_aw_addr   = r_aw_held ? r_awaddr : s00_axil_awaddr;
    assign w_wdec      = f_decode(w_aw_addr, 1'b1);
    assign w_m_awready = {m01_axil_awready, m00_axil_awready};
    assign w_m_wready  = {m01_axil_wready, m00_axil_wready};
    assign w_m_bvalid  = {m01_axil_bvalid, m00_axil_bvalid};
    assign w_m_bresp   = r_wsel ? m01_axil_bresp : m00_axil_bresp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate    <= W_IDLE;
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_wsel      <= 1'b0;
            r_awaddr    <= '0;
            r_awprot    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_s_awready <= 1'b0;
            r_s_wready  <= 1'b0;
            r_s_bvalid  <= 1'b0;
            r_s_bresp   <= '0;
            r_m_awvalid <= '0;
            r_m_wvalid  <= '0;
            r_m_bready  <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr <= s00_axil_awaddr;
                        r_awprot <= s00_axil_awprot;
                    end
                    if (w_w_hs) begin
                        r_wdata <= s00_axil_wdata;
                        r_wstrb <= s00_axil_wstrb;
                    end
                    if (w_aw_have && w_w_have) begin
                        r_aw_held   <= 1'b0;
                        r_w_held    <= 1'b0;
                        r_s_awready <= 1'b0;
                        r_s_wready  <= 1'b0;
                        if (w_wdec[1]) begin
                            r_wsel                <= w_wdec[0];
                            r_m_awvalid[w_wdec[0]] <= 1'b1;
                            r_m_wvalid[w_wdec[0]]  <= 1'b1;
                            r_wstate              <= W_ISSUE;
                        end else begin
                            r_s_bresp  <= 2'b11;
                            r_s_bvalid <= 1'b1;
                            r_wstate   <= W_RESP;
                        end
                    end else begin
                        r_aw_held   <= w_aw_have;
                        r_w_held    <= w_w_have;
                        r_s_awready <= ~w_aw_have;
                        r_s_wready  <= ~w_w_have;
                    end
                end
                W_ISSUE: begin
                    if (w_m_awready[r_wsel]) r_m_awvalid[r_wsel] <= 1'b0;
                    if (w_m_wready[r_wsel])  r_m_wvalid[r_wsel]  <= 1'b0;
                    if ((!r_m_awvalid[r_wsel] || w_m_awready[r_wsel]) &&
                        (!r_m_wvalid[r_wsel]  || w_m_wready[r_wsel])) begin
                        r_m_bready[r_wsel] <= 1'b1;
                        r_wstate           <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_m_bvalid[r_wsel]) begin
                        r_s_bresp          <= w_m_bresp;
                        r_m_bready[r_wsel] <= 1'b0;
                        r_s_bvalid         <= 1'b1;
                        r_wstate           <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s00_axil_bready) begin
                        r_s_bvalid  <= 1'b0;
                        r_s_awready <= 1'b1;
                        r_s_wready  <= 1'b1;
                        r_wstate    <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    r_state_t              r_rstate;
    logic                  r_rsel;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [2:0]            r_arprot;
    logic                  r_s_arready, r_s_rvalid;
    logic [DATA_WIDTH-1:0] r_s_rdata;
    logic [1:0]            r_s_rresp;
    logic [1:0]            r_m_arvalid, r_m_rready;

    logic                  w_ar_hs;
    logic [1:0]            w_rdec, w_m_arready, w_m_rvalid, w_m_rresp;
    logic [DATA_WIDTH-1:0] w_m_rdata;

    assign w_ar_hs     = s00_axil_arvalid & r_s_arready;
    assign w_rdec      = f_decode(s00_axil_araddr, 1'b0);
    assign w_m_arready = {m01_axil_arready, m00_axil_arready};
    assign w_m_rvalid  = {m01_axil_rvalid, m00_axil_rvalid};
    assign w_m_rresp   = r_rsel ? m01_axil_rresp : m00_axil_rresp;
    assign w_m_rdata   = r_rsel ? m01_axil_rdata : m00_axil_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate    <= R_IDLE;
            r_rsel      <= 1'b0;
            r_araddr    <= '0;
            r_arprot    <= '0;
            r_s_arready <= 1'b0;
            r_s_rvalid  <= 1'b0;
            r_s_rdata   <= '0;
            r_s_rresp   <= '0;
            r_m_arvalid <= '0;
            r_m_rready  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_araddr    <= s00_axil_araddr;
                        r_arprot    <= s00_axil_arprot;
                        r_s_arready <= 1'b0;
                        if (w_rdec[1]) begin
                            r_rsel                 <= w_rdec[0];
                            r_m_arvalid[w_rdec[0]] <= 1'b1;
                            r_rstate               <= R_ISSUE;
                        end else begin
                            r_s_rdata  <= '0;
                            r_s_rresp  <= 2'b11;
                            r_s_rvalid <= 1'b1;
                            r_rstate   <= R_RESP;
                        end
                    end else begin
                        r_s_arready <= 1'b1;
                    end
                end
                R_ISSUE: begin
                    if (w_m_arready[r_rsel]) begin
                        r_m_arvalid[r_rsel] <= 1'b0;
                        r_m_rready[r_rsel]  <= 1'b1;
                        r_rstate            <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (w_m_rvalid[r_rsel]) begin
                        r_s_rdata          <= w_m_rdata;
                        r_s_rresp          <= w_m_rresp;
                        r_m_rready[r_rsel] <= 1'b0;
                        r_s_rvalid         <= 1'b1;
                        r_rstate           <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s00_axil_rready) begin
                        r_s_rvalid  <= 1'b0;
                        r_s_arready <= 1'b1;
                        r_rstate    <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign s00_axil_awready = r_s_awready;
    assign s00_axil_wready  = r_s_wready;
    assign s00_axil_bresp   = r_s_bresp;
    assign s00_axil_bvalid  = r_s_bvalid;
    assign s00_axil_arready = r_s_arready;
    assign s00_axil_rdata   = r_s_rdata;
    assign s00_axil_rresp   = r_s_rresp;
    assign s00_axil_rvalid  = r_s_rvalid;

    // Payload is shared by both master ports; only the valids are steered.
    assign m00_axil_awaddr  = r_awaddr;
    assign m00_axil_awprot  = r_awprot;
    assign m00_axil_awvalid = r_m_awvalid[0];
    assign m00_axil_wdata   = r_wdata;
    assign m00_axil_wstrb   = r_wstrb;
    assign m00_axil_wvalid  = r_m_wvalid[0];
    assign m00_axil_bready  = r_m_bready[0];
    assign m00_axil_araddr  = r_araddr;
    assign m00_axil_arprot  = r_arprot;
    assign m00_axil_arvalid = r_m_arvalid[0];
    assign m00_axil_rready  = r_m_rready[0];

    assign m01_axil_awaddr  = r_awaddr;
    assign m01_axil_awprot  = r_awprot;
    assign m01_axil_awvalid = r_m_awvalid[1];
    assign m01_axil_wdata   = r_wdata;
    assign m01_axil_wstrb   = r_wstrb;
    assign m01_axil_wvalid  = r_m_wvalid[1];
    assign m01_axil_bready  = r_m_bready[1];
    assign m01_axil_araddr  = r_araddr;
    assign m01_axil_arprot  = r_arprot;
    assign m01_axil_arvalid = r_m_arvalid[1];
    assign m01_axil_rready  = r_m_rready[1];

endmodule

// File: tb/tb_axil_interconnect_1x2.sv
module tb_axil_interconnect_1x2;

    logic clk, rst;

    // s00 side (driven by the main initial block)
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    wire         s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    wire  [1:0]  s_bresp, s_rresp;
    wire  [31:0] s_rdata;

    // master side: index 0 = m00, 1 = m01
    wire  [1:0][31:0] maw_addr, mw_data, mar_addr;
    wire  [1:0][2:0]  maw_prot, mar_prot;
    wire  [1:0][3:0]  mw_strb;
    wire  [1:0]       mawv, mwv, mbrdy, marv, mrrdy;
    logic [1:0]       awr, wr, bv, arr, rv;
    logic [1:0][1:0]  bresp_m, rresp_m;
    logic [1:0][31:0] rdata_m;

    // target model state (written only by the model process)
    logic [1:0]       awg, wg, arg;
    int               cnt_aw [2], cnt_ar [2], seen_awv [2], seen_arv [2];
    logic [31:0]      cap_awaddr [2], cap_wdata [2], cap_araddr [2];
    logic [3:0]       cap_wstrb [2];
    logic [2:0]       cap_awprot [2], cap_arprot [2];
    logic             stall_aw;

    int total, bad;

    typedef struct { int mst; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic [1:0] resp; } wexp_t;
    typedef struct { int mst; logic [31:0] addr; logic [31:0] data; logic [1:0] resp; } rexp_t;
    wexp_t sb_w[$];
    rexp_t sb_r[$];

    axil_interconnect_1x2 #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .M00_BASE_ADDR(32'h0000_0000), .M00_ADDR_WIDTH(17),
        .M00_CONNECT_READ(1'b1), .M00_CONNECT_WRITE(1'b1),
        .M01_BASE_ADDR(32'h1000_0000), .M01_ADDR_WIDTH(4),
        .M01_CONNECT_READ(1'b0), .M01_CONNECT_WRITE(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .s00_axil_awaddr(s_awaddr), .s00_axil_awprot(s_awprot), .s00_axil_awvalid(s_awvalid), .s00_axil_awready(s_awready),
        .s00_axil_wdata(s_wdata), .s00_axil_wstrb(s_wstrb), .s00_axil_wvalid(s_wvalid), .s00_axil_wready(s_wready),
        .s00_axil_bresp(s_bresp), .s00_axil_bvalid(s_bvalid), .s00_axil_bready(s_bready),
        .s00_axil_araddr(s_araddr), .s00_axil_arprot(s_arprot), .s00_axil_arvalid(s_arvalid), .s00_axil_arready(s_arready),
        .s00_axil_rdata(s_rdata), .s00_axil_rresp(s_rresp), .s00_axil_rvalid(s_rvalid), .s00_axil_rready(s_rready),
        .m00_axil_awaddr(maw_addr[0]), .m00_axil_awprot(maw_prot[0]), .m00_axil_awvalid(mawv[0]), .m00_axil_awready(awr[0]),
        .m00_axil_wdata(mw_data[0]), .m00_axil_wstrb(mw_strb[0]), .m00_axil_wvalid(mwv[0]), .m00_axil_wready(wr[0]),
        .m00_axil_bresp(bresp_m[0]), .m00_axil_bvalid(bv[0]), .m00_axil_bready(mbrdy[0]),
        .m00_axil_araddr(mar_addr[0]), .m00_axil_arprot(mar_prot[0]), .m00_axil_arvalid(marv[0]), .m00_axil_arready(arr[0]),
        .m00_axil_rdata(rdata_m[0]), .m00_axil_rresp(rresp_m[0]), .m00_axil_rvalid(rv[0]), .m00_axil_rready(mrrdy[0]),
        .m01_axil_awaddr(maw_addr[1]), .m01_axil_awprot(maw_prot[1]), .m01_axil_awvalid(mawv[1]), .m01_axil_awready(awr[1]),
        .m01_axil_wdata(mw_data[1]), .m01_axil_wstrb(mw_strb[1]), .m01_axil_wvalid(mwv[1]), .m01_axil_wready(wr[1]),
        .m01_axil_bresp(bresp_m[1]), .m01_axil_bvalid(bv[1]), .m01_axil_bready(mbrdy[1]),
        .m01_axil_araddr(mar_addr[1]), .m01_axil_arprot(mar_prot[1]), .m01_axil_arvalid(marv[1]), .m01_axil_arready(arr[1]),
        .m01_axil_rdata(rdata_m[1]), .m01_axil_rresp(rresp_m[1]), .m01_axil_rvalid(rv[1]), .m01_axil_rready(mrrdy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Simple target behind each master port: one-cycle ready pulses, B/R
    // returned the cycle after the DUT raises bready/rready. Read data is
    // the address XOR 0x5A5A_0000.
    initial begin
        awr = '0; wr = '0; bv = '0; arr = '0; rv = '0;
        bresp_m = '0; rresp_m = '0; rdata_m = '0; awg = '0; wg = '0; arg = '0;
        for (int i = 0; i < 2; i++) begin
            cnt_aw[i] = 0; cnt_ar[i] = 0; seen_awv[i] = 0; seen_arv[i] = 0;
            cap_awaddr[i] = '0; cap_wdata[i] = '0; cap_araddr[i] = '0;
            cap_wstrb[i] = '0; cap_awprot[i] = '0; cap_arprot[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    awr[i] = 0; wr[i] = 0; bv[i] = 0; arr[i] = 0; rv[i] = 0;
                    awg[i] = 0; wg[i] = 0; arg[i] = 0;
                end else begin
                    if (mawv[i]) seen_awv[i]++;
                    if (marv[i]) seen_arv[i]++;
                    awr[i] = 0; wr[i] = 0; arr[i] = 0;
                    if (mawv[i] && !awg[i] && !stall_aw) begin
                        awr[i] = 1; awg[i] = 1; cnt_aw[i]++;
                        cap_awaddr[i] = maw_addr[i]; cap_awprot[i] = maw_prot[i];
                    end
                    if (mwv[i] && !wg[i]) begin
                        wr[i] = 1; wg[i] = 1;
                        cap_wdata[i] = mw_data[i]; cap_wstrb[i] = mw_strb[i];
                    end
                    if (bv[i] && !mbrdy[i]) bv[i] = 0;
                    else if (!bv[i] && awg[i] && wg[i] && mbrdy[i]) begin
                        bv[i] = 1; bresp_m[i] = 2'b00; awg[i] = 0; wg[i] = 0;
                    end
                    if (marv[i] && !arg[i]) begin
                        arr[i] = 1; arg[i] = 1; cnt_ar[i]++;
                        cap_araddr[i] = mar_addr[i]; cap_arprot[i] = mar_prot[i];
                    end
                    if (rv[i] && !mrrdy[i]) rv[i] = 0;
                    else if (!rv[i] && arg[i] && mrrdy[i]) begin
                        rv[i] = 1; rdata_m[i] = cap_araddr[i] ^ 32'h5A5A_0000;
                        rresp_m[i] = 2'b00; arg[i] = 0;
                    end
                end
            end
        end
    end

    function automatic logic [14:0] all_vr();
        return {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, mawv, mwv, mbrdy, marv, mrrdy};
    endfunction

    // mst = -1 means a locally generated DECERR is expected
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input int bhold, input int mst, input logic [1:0] resp);
        wexp_t e;
        int cyc, a0 [2], s0 [2];
        bit aw_hs, w_hs, aw_go, w_go, stable;
        for (int i = 0; i < 2; i++) begin a0[i] = cnt_aw[i]; s0[i] = seen_awv[i]; end
        sb_w.push_back('{mst, addr, data, strb, resp});
        cyc = 0; aw_hs = 0; w_hs = 0;
        @(negedge clk);
        s_wdata = data; s_wstrb = strb; s_wvalid = 1;
        s_awprot = 3'b010;
        if (w_lead == 0) begin s_awaddr = addr; s_awvalid = 1; end
        while (!(aw_hs && w_hs) && cyc < 50) begin
            aw_go = s_awvalid && s_awready;
            w_go  = s_wvalid && s_wready;
            @(negedge clk); cyc++;
            if (aw_go) begin s_awvalid = 0; aw_hs = 1; end
            if (w_go)  begin s_wvalid = 0; w_hs = 1; end
            if (cyc == w_lead && !aw_hs && !s_awvalid) begin s_awaddr = addr; s_awvalid = 1; end
        end
        total++;
        if (!(aw_hs && w_hs)) begin bad++; $display("FAIL wr_capture addr=%h timeout aw=%b w=%b", addr, aw_hs, w_hs); return; end
        if (mst >= 0) begin
            total++;
            if ({mawv[mst], mwv[mst]} !== 2'b11) begin
                bad++; $display("FAIL wr_issue_latency addr=%h awvalid/wvalid=%b want 11", addr, {mawv[mst], mwv[mst]});
            end
        end
        cyc = 0;
        while (!s_bvalid && cyc < 100) begin @(negedge clk); cyc++; end
        e = sb_w.pop_front();
        total++;
        if (!s_bvalid) begin bad++; $display("FAIL wr_bvalid addr=%h timeout", addr); return; end
        if (s_bresp !== e.resp) begin bad++; $display("FAIL wr_bresp addr=%h got=%b want=%b", addr, s_bresp, e.resp); end
        if (e.mst < 0) begin
            total++;
            if (cyc != 0) begin bad++; $display("FAIL decerr_latency addr=%h got=%0d want=0 cycles", addr, cyc); end
        end
        stable = 1;
        for (int k = 0; k < bhold; k++) begin
            @(negedge clk);
            if (s_bvalid !== 1'b1 || s_bresp !== e.resp) stable = 0;
        end
        if (bhold > 0) begin
            total++;
            if (!stable) begin bad++; $display("FAIL b_hold addr=%h bvalid/bresp changed before bready", addr); end
        end
        s_bready = 1;
        @(negedge clk);
        s_bready = 0;
        total++;
        if (s_bvalid !== 1'b0) begin bad++; $display("FAIL b_drop addr=%h bvalid=%b want 0", addr, s_bvalid); end
        if (e.mst >= 0) begin
            total++;
            if (cap_awaddr[e.mst] !== e.addr || cap_wdata[e.mst] !== e.data ||
                cap_wstrb[e.mst] !== e.strb || cap_awprot[e.mst] !== 3'b010) begin
                bad++;
                $display("FAIL wr_payload m%0d got addr=%h data=%h strb=%h prot=%b want addr=%h data=%h strb=%h prot=010",
                         e.mst, cap_awaddr[e.mst], cap_wdata[e.mst], cap_wstrb[e.mst], cap_awprot[e.mst], e.addr, e.data, e.strb);
            end
            total++;
            if (cnt_aw[e.mst] - a0[e.mst] != 1 || seen_awv[1-e.mst] != s0[1-e.mst]) begin
                bad++;
                $display("FAIL wr_routing m%0d got aw_count=%0d other_valid_cycles=%0d want 1/0",
                         e.mst, cnt_aw[e.mst] - a0[e.mst], seen_awv[1-e.mst] - s0[1-e.mst]);
            end
        end else begin
            total++;
            if (seen_awv[0] != s0[0] || seen_awv[1] != s0[1]) begin
                bad++; $display("FAIL decerr_untouched addr=%h awvalid cycles m00=%0d m01=%0d want 0/0",
                                addr, seen_awv[0] - s0[0], seen_awv[1] - s0[1]);
            end
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int mst, input logic [31:0] data, input logic [1:0] resp);
        rexp_t e;
        int cyc, c0 [2], s0 [2];
        bit go, hs;
        for (int i = 0; i < 2; i++) begin c0[i] = cnt_ar[i]; s0[i] = seen_arv[i]; end
        sb_r.push_back('{mst, addr, data, resp});
        cyc = 0; hs = 0;
        @(negedge clk);
        s_araddr = addr; s_arprot = 3'b001; s_arvalid = 1;
        while (!hs && cyc < 50) begin
            go = s_arvalid && s_arready;
            @(negedge clk); cyc++;
            if (go) begin s_arvalid = 0; hs = 1; end
        end
        total++;
        if (!hs) begin bad++; $display("FAIL rd_capture addr=%h timeout", addr); s_arvalid = 0; return; end
        if (mst >= 0) begin
            total++;
            if (marv[mst] !== 1'b1) begin bad++; $display("FAIL rd_issue_latency addr=%h arvalid=%b want 1", addr, marv[mst]); end
        end
        cyc = 0;
        while (!s_rvalid && cyc < 100) begin @(negedge clk); cyc++; end
        e = sb_r.pop_front();
        total++;
        if (!s_rvalid) begin bad++; $display("FAIL rd_rvalid addr=%h timeout", addr); return; end
        if (s_rresp !== e.resp || s_rdata !== e.data) begin
            bad++; $display("FAIL rd_resp addr=%h got rresp=%b rdata=%h want rresp=%b rdata=%h", addr, s_rresp, s_rdata, e.resp, e.data);
        end
        if (e.mst < 0) begin
            total++;
            if (cyc != 0) begin bad++; $display("FAIL rd_decerr_latency addr=%h got=%0d want=0 cycles", addr, cyc); end
        end
        s_rready = 1;
        @(negedge clk);
        s_rready = 0;
        total++;
        if (s_rvalid !== 1'b0) begin bad++; $display("FAIL r_drop addr=%h rvalid=%b want 0", addr, s_rvalid); end
        total++;
        if (e.mst >= 0) begin
            if (cnt_ar[e.mst] - c0[e.mst] != 1 || cap_araddr[e.mst] !== e.addr || cap_arprot[e.mst] !== 3'b001 ||
                seen_arv[1-e.mst] != s0[1-e.mst]) begin
                bad++; $display("FAIL rd_routing m%0d got count=%0d addr=%h prot=%b want 1 %h 001",
                                e.mst, cnt_ar[e.mst] - c0[e.mst], cap_araddr[e.mst], cap_arprot[e.mst], e.addr);
            end
        end else if (seen_arv[0] != s0[0] || seen_arv[1] != s0[1]) begin
            bad++; $display("FAIL rd_untouched addr=%h arvalid cycles m00=%0d m01=%0d want 0/0",
                            addr, seen_arv[0] - s0[0], seen_arv[1] - s0[1]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (all_vr() !== 15'd0 || s_bresp !== 2'b00 || s_rresp !== 2'b00 || s_rdata !== 32'd0 || maw_addr[0] !== 32'd0) begin
            bad++; $display("FAIL reset_values got vr=%b bresp=%b rresp=%b rdata=%h awaddr=%h want all 0",
                            all_vr(), s_bresp, s_rresp, s_rdata, maw_addr[0]);
        end
        rst = 0;
        #1;
        total++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            bad++; $display("FAIL ready_before_edge got=%b want 000", {s_awready, s_wready, s_arready});
        end
        @(negedge clk);
        total++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            bad++; $display("FAIL ready_after_edge got=%b want 111", {s_awready, s_wready, s_arready});
        end
    endtask

    task automatic test_write_m00();
        do_write(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00);
    endtask

    task automatic test_write_m01();
        do_write(32'h1000_0004, 32'h0000_0001, 4'hF, 0, 0, 1, 2'b00);
    endtask

    task automatic test_read_m00();
        do_read(32'h0000_0040, 0, 32'h0000_0040 ^ 32'h5A5A_0000, 2'b00);
    endtask

    task automatic test_read_disconnected();
        do_read(32'h1000_0000, -1, 32'h0, 2'b11);
    endtask

    task automatic test_write_unmapped();
        do_write(32'h3000_0000, 32'h1234_5678, 4'hF, 0, 0, -1, 2'b11);
    endtask

    task automatic test_w_before_aw_bp();
        do_write(32'h0000_1000, 32'hA5A5_0F0F, 4'hF, 2, 5, 0, 2'b00);
    endtask

    task automatic test_back_to_back();
        do_write(32'h1000_0008, 32'hCAFE_F00D, 4'h3, 0, 0, 1, 2'b00);
        do_read(32'h0001_FFFC, 0, 32'h0001_FFFC ^ 32'h5A5A_0000, 2'b00);
        do_write(32'h0002_0000, 32'h0BAD_0BAD, 4'hF, 0, 0, -1, 2'b11);
        do_write(32'h1000_0010, 32'h0000_0002, 4'hF, 0, 0, -1, 2'b11);
        do_write(32'h0001_FFFC, 32'h7777_8888, 4'hC, 1, 2, 0, 2'b00);
    endtask

    task automatic test_reset_abort();
        int cyc;
        bit quiet;
        stall_aw = 1;
        @(negedge clk);
        s_awaddr = 32'h0000_0200; s_awvalid = 1; s_wdata = 32'h1111_2222; s_wstrb = 4'hF; s_wvalid = 1;
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0;
        cyc = 0;
        while (!mawv[0] && cyc < 20) begin @(negedge clk); cyc++; end
        repeat (2) @(negedge clk);
        total++;
        if (mawv[0] !== 1'b1) begin bad++; $display("FAIL abort_pending m00 awvalid=%b want 1", mawv[0]); end
        rst = 1;
        #1;
        total++;
        if (all_vr() !== 15'd0) begin bad++; $display("FAIL abort_outputs got=%b want all 0", all_vr()); end
        repeat (2) @(negedge clk);
        rst = 0; stall_aw = 0;
        quiet = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (s_bvalid || mawv != 2'b00 || mwv != 2'b00) quiet = 0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL abort_no_resp bvalid or master valid seen after reset release"); end
        do_read(32'h0000_0000, 0, 32'h5A5A_0000, 2'b00);
    endtask

    initial begin
        total = 0; bad = 0; stall_aw = 0;
        rst = 1;
        s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
        s_bready = 0; s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
        test_reset();
        test_write_m00();
        test_write_m01();
        test_read_m00();
        test_read_disconnected();
        test_write_unmapped();
        test_w_before_aw_bp();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
